alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer that shares one combinational `alu` (AND/OR/ADD/SUB/SLT, 32-bit) between two clients. It accepts an operation over a valid/ready handshake, registers the operands, evaluates them through the shared `alu`, and returns the result and flags to the owning requester over a second valid/ready handshake. It sits between the datapath clients (e.g. the execute stage and a multi-cycle helper) and the single ALU instance.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must match `alu`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid[1:0]` in 2: request valid, one bit per requester.
- `req_ready[1:0]` out 2: request accepted this cycle, one-hot or zero.
- `req_A0`, `req_B0`, `req_A1`, `req_B1` in DATA_WIDTH: operands per requester.
- `req_op0`, `req_op1` in 3: ALUop per requester: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
- `resp_valid[1:0]` out 2: response valid, at most one bit set.
- `resp_ready[1:0]` in 2: requester accepts response.
- `resp_result` out DATA_WIDTH: registered `alu` Result, shared by both requesters.
- `resp_flags` out 3: registered {Overflow, CarryOut, Zero}.
- `resp_err` out 1: illegal op (see Configuration).

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: `grant` is combinational. If only one `req_valid` bit is set, that requester wins. If both are set, requester `rr_ptr` wins. `req_ready[grant]=1` only in IDLE. On `req_valid & req_ready`, latch A, B, op, owner=grant; set `rr_ptr <= ~grant`; go to EXEC.
- EXEC: the `alu` is driven from the latched registers. Capture Result into `resp_result` and {Overflow,CarryOut,Zero} into `resp_flags`; go to RESP.
- RESP: `resp_valid[owner]=1`. Result and flags are held stable. On `resp_ready[owner]`, go to IDLE. `resp_ready` of the non-owner is ignored.
- CarryOut follows `alu` semantics: carry for ADD, borrow (inverted carry) for SUB/SLT.
- No new request is accepted outside IDLE. `req_ready` is 0 in EXEC and RESP.

## Timing
- Reset values: `req_ready`=0 during reset, `resp_valid`=0, `resp_result`=0, `resp_flags`=0, `resp_err`=0, `rr_ptr`=0, state=IDLE.
- Accept at edge N. `resp_valid` is high from cycle N+2. Minimum throughput is one operation per 3 cycles when `resp_ready` is held high.
- `req_ready` can assert in the same cycle `req_valid` rises, if in IDLE.
- Response handshake at edge M: state is IDLE at M+1, and a new accept is possible at M+1.
- A requester dropping `req_valid` in IDLE before acceptance is legal; grant re-evaluates each cycle.
- An `rst_n` assertion in any state immediately clears all state and outputs. The in-flight operation is discarded and no response is produced.

## Configuration
- `ALU_ARB_ILLEGAL_OP_EN` defined: op not in {000,001,010,110,111} is detected at accept. The response carries `resp_err=1`, `resp_result=0`, `resp_flags=0`, and the `alu` output is ignored.
- Undefined: `resp_err` is tied to 0. Every op is passed to the `alu` unchanged, and the response is whatever the `alu` produces (Result 0, Zero=1 for undefined ops).

## Structure
- Shared package/header `alu_pkg`: ALUop localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT), FSM state encodings, flag bit indices (FLG_OV=2, FLG_CO=1, FLG_Z=0).
- One sub-module: the existing `alu`, instantiated once. The round-robin pick is inline logic.

## Test plan
- Reset, then req0 A=5, B=3, op=010 -> `req_ready[0]` same cycle. `resp_valid[0]` 2 cycles later, result=8, flags=000.
- req0 and req1 valid together after reset. req0: A=1, B=1, op=110 -> result 0, flags=001, served first. req1: A=0x7FFFFFFF, B=1, op=010 -> result 0x80000000, flags=100, served next.
- Hold `resp_ready[0]`=0 for 5 cycles while req1 is valid -> `resp_valid[0]`, result and flags stay stable, `req_ready[1]`=0. Releasing `resp_ready[0]` -> req1 is accepted the cycle after the response handshake.
- SLT A=0xFFFFFFFF, B=1 -> result 1. SUB A=0, B=1 -> result 0xFFFFFFFF, flags=010 (borrow).
- Assert `rst_n` low during EXEC -> all outputs 0 immediately. After release, no response is issued and `rr_ptr`=0.
- op=011, A=7, B=7: with the macro -> `resp_err`=1, result 0, flags 000. Without the macro -> `resp_err`=0, result 0, flags 001.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter: op codes, flag bit
// positions and arbiter FSM states.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int unsigned FLG_OV = 2;
  localparam int unsigned FLG_CO = 1;
  localparam int unsigned FLG_Z  = 0;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } arb_state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: op_is_legal = 1'b1;
      default:                               op_is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU (AND/OR/ADD/SUB/SLT). Undefined ops give result 0 with Zero set;
// CarryOut is the carry for ADD and the borrow for SUB/SLT. SLT never reports overflow.
module alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [2:0]            alu_op,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  carry_out,
  output logic                  zero
);

  localparam int unsigned Msb = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0] sum_add;
  logic [DATA_WIDTH:0] sum_sub;
  logic                ov_add;
  logic                ov_sub;

  assign sum_add = {1'b0, a} + {1'b0, b};
  assign sum_sub = {1'b0, a} + {1'b0, ~b} + {{DATA_WIDTH{1'b0}}, 1'b1};

  assign ov_add = (a[Msb] == b[Msb]) && (sum_add[Msb] != a[Msb]);
  assign ov_sub = (a[Msb] != b[Msb]) && (sum_sub[Msb] != a[Msb]);

  always_comb begin
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    case (alu_op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_ADD: begin
        result    = sum_add[Msb:0];
        overflow  = ov_add;
        carry_out = sum_add[DATA_WIDTH];
      end
      OP_SUB: begin
        result    = sum_sub[Msb:0];
        overflow  = ov_sub;
        carry_out = ~sum_sub[DATA_WIDTH];
      end
      OP_SLT: begin
        // Signed less-than: sign of the difference corrected by overflow.
        result    = {{Msb{1'b0}}, sum_sub[Msb] ^ ov_sub};
        carry_out = ~sum_sub[DATA_WIDTH];
      end
      default: ;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one alu between two requesters.
// Optional illegal-op detection is enabled by defining ALU_ARB_ILLEGAL_OP_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [DATA_WIDTH-1:0] req_A0,
  input  logic [DATA_WIDTH-1:0] req_B0,
  input  logic [DATA_WIDTH-1:0] req_A1,
  input  logic [DATA_WIDTH-1:0] req_B1,
  input  logic [2:0]            req_op0,
  input  logic [2:0]            req_op1,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic [2:0]            resp_flags,
  output logic                  resp_err
);

  arb_state_e            state_q;
  logic                  rr_ptr_q;
  logic                  owner_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [2:0]            op_q;

  logic                  grant;
  logic                  accept;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [2:0]            sel_op;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_ov;
  logic                  alu_co;
  logic                  alu_z;

`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic err_q;
  logic resp_err_q;
  assign resp_err = resp_err_q;
`else
  assign resp_err = 1'b0;
`endif

  // Single requester wins outright; on contention the round-robin pointer decides.
  always_comb begin
    case (req_valid)
      2'b10:   grant = 1'b1;
      2'b11:   grant = rr_ptr_q;
      default: grant = 1'b0;
    endcase
    req_ready = 2'b00;
    if (rst_n && (state_q == StIdle) && (req_valid != 2'b00)) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);
  assign sel_a  = grant ? req_A1  : req_A0;
  assign sel_b  = grant ? req_B1  : req_B0;
  assign sel_op = grant ? req_op1 : req_op0;

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a        (a_q),
    .b        (b_q),
    .alu_op   (op_q),
    .result   (alu_result),
    .overflow (alu_ov),
    .carry_out(alu_co),
    .zero     (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_flags  <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_q       <= 1'b0;
      resp_err_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            a_q      <= sel_a;
            b_q      <= sel_b;
            op_q     <= sel_op;
            owner_q  <= grant;
            rr_ptr_q <= ~grant;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q    <= ~op_is_legal(sel_op);
`endif
            state_q  <= StExec;
          end
        end
        StExec: begin
          resp_result        <= alu_result;
          resp_flags[FLG_OV] <= alu_ov;
          resp_flags[FLG_CO] <= alu_co;
          resp_flags[FLG_Z]  <= alu_z;
`ifdef ALU_ARB_ILLEGAL_OP_EN
          resp_err_q <= err_q;
          if (err_q) begin
            resp_result <= '0;
            resp_flags  <= '0;
          end
`endif
          resp_valid <= owner_q ? 2'b10 : 2'b01;
          state_q    <= StResp;
        end
        StResp: begin
          if (resp_ready[owner_q]) begin
            resp_valid <= 2'b00;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against an arithmetic reference model and a round-robin pointer model.
module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct packed {
    logic        err;
    logic [2:0]  flags;
    logic [31:0] r;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_A0, req_B0, req_A1, req_B1;
  logic [2:0]  req_op0, req_op1;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_result;
  logic [2:0]  resp_flags;
  logic        resp_err;

  int          n_cmp;
  int          n_err;
  logic        rr;
  logic [31:0] last_result;
  logic [2:0]  last_flags;
  logic        last_err;

  alu_arbiter #(
    .DATA_WIDTH(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_A0     (req_A0),
    .req_B0     (req_B0),
    .req_A1     (req_A1),
    .req_B1     (req_B1),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_flags (resp_flags),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic and range checks.
  function automatic exp_t ref_alu(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
    exp_t            e;
    longint          sa, sb, sr;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    e  = '0;
    case (op)
      3'd0: e.r = a & b;
      3'd1: e.r = a | b;
      3'd2: begin
        e.r        = 32'(ua + ub);
        e.flags[1] = (ua + ub) > 64'hFFFF_FFFF;
        sr         = sa + sb;
        e.flags[2] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd6: begin
        e.r        = 32'(ua - ub);
        e.flags[1] = ua < ub;
        sr         = sa - sb;
        e.flags[2] = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd7: begin
        e.r        = (sa < sb) ? 32'd1 : 32'd0;
        e.flags[1] = ua < ub;
      end
      default: e.r = 32'd0;
    endcase
    e.flags[0] = (e.r == 32'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd6 || op == 3'd7)) begin
      e     = '0;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] pick_op();
    case ($urandom_range(0, 9))
      0:       return OP_AND;
      1:       return OP_OR;
      2, 3:    return OP_ADD;
      4, 5:    return OP_SUB;
      6, 7:    return OP_SLT;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b01;
    resp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_result", 64'(resp_result), 64'd0);
    check("rst_flags", 64'(resp_flags), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    rr    = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from IDLE with the currently driven requests; holds the
  // response for 'hold' cycles with only the non-owner's resp_ready high.
  task automatic serve(input int hold);
    logic       g;
    logic [1:0] m;
    exp_t       e;
    g = (req_valid == 2'b11) ? rr : req_valid[1];
    m = g ? 2'b10 : 2'b01;
    e = g ? ref_alu(req_op1, req_A1, req_B1) : ref_alu(req_op0, req_A0, req_B0);
    #1;
    check("accept_ready", 64'(req_ready), 64'(m));
    @(posedge clk);
    #1;
    rr           = ~g;
    req_valid[g] = 1'b0;
    check("exec_ready", 64'(req_ready), 64'd0);
    check("exec_valid", 64'(resp_valid), 64'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i <= hold; i++) begin
      resp_ready = (i == hold) ? m : ~m;
      check("resp_valid", 64'(resp_valid), 64'(m));
      check("resp_result", 64'(resp_result), 64'(e.r));
      check("resp_flags", 64'(resp_flags), 64'(e.flags));
      check("resp_err", 64'(resp_err), 64'(e.err));
      check("resp_req_ready", 64'(req_ready), 64'd0);
      last_result = resp_result;
      last_flags  = resp_flags;
      last_err    = resp_err;
      @(posedge clk);
      #1;
    end
    resp_ready = 2'b00;
    check("resp_done", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rr    = 1'b0;
    rst_n = 1'b0;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    req_A0 = '0; req_B0 = '0; req_A1 = '0; req_B1 = '0;
    req_op0 = '0; req_op1 = '0;

    // Single ADD on requester 0.
    do_reset();
    req_A0 = 32'd5; req_B0 = 32'd3; req_op0 = OP_ADD; req_valid = 2'b01;
    serve(0);
    check("t1_result", 64'(last_result), 64'd8);
    check("t1_flags", 64'(last_flags), 64'd0);

    // Contention after reset, with a stalled response while requester 1 waits.
    do_reset();
    req_A0 = 32'd1; req_B0 = 32'd1; req_op0 = OP_SUB;
    req_A1 = 32'h7FFF_FFFF; req_B1 = 32'd1; req_op1 = OP_ADD;
    req_valid = 2'b11;
    serve(5);
    check("t2_r0_result", 64'(last_result), 64'd0);
    check("t2_r0_flags", 64'(last_flags), 64'b001);
    serve(0);
    check("t2_r1_result", 64'(last_result), 64'h8000_0000);
    check("t2_r1_flags", 64'(last_flags), 64'b100);

    // SLT and SUB borrow.
    req_A1 = 32'hFFFF_FFFF; req_B1 = 32'd1; req_op1 = OP_SLT; req_valid = 2'b10;
    serve(1);
    check("t3_slt", 64'(last_result), 64'd1);
    req_A1 = 32'd0; req_B1 = 32'd1; req_op1 = OP_SUB; req_valid = 2'b10;
    serve(0);
    check("t3_sub", 64'(last_result), 64'hFFFF_FFFF);
    check("t3_sub_flags", 64'(last_flags), 64'b010);

    // Reset while in EXEC discards the operation.
    req_A0 = 32'd10; req_B0 = 32'd20; req_op0 = OP_ADD; req_valid = 2'b01;
    #1;
    check("t4_ready", 64'(req_ready), 64'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    check("t4_valid", 64'(resp_valid), 64'd0);
    check("t4_result", 64'(resp_result), 64'd0);
    check("t4_flags", 64'(resp_flags), 64'd0);
    check("t4_err", 64'(resp_err), 64'd0);
    check("t4_ready_rst", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    rst_n      = 1'b1;
    rr         = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("t4_no_resp", 64'(resp_valid), 64'd0);
    end
    resp_ready = 2'b00;
    req_A0 = 32'hF0F0; req_B0 = 32'hFF00; req_op0 = OP_AND;
    req_A1 = 32'h1;    req_B1 = 32'h2;    req_op1 = OP_OR;
    req_valid = 2'b11;
    serve(0);
    check("t4_rr_reset", 64'(last_result), 64'hF000);
    req_valid = 2'b00;

    // Undefined op 011.
    req_A0 = 32'd7; req_B0 = 32'd7; req_op0 = 3'b011; req_valid = 2'b01;
    serve(0);
    check("t5_result", 64'(last_result), 64'd0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    check("t5_err", 64'(last_err), 64'd1);
    check("t5_flags", 64'(last_flags), 64'b000);
`else
    check("t5_err", 64'(last_err), 64'd0);
    check("t5_flags", 64'(last_flags), 64'b001);
`endif

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      req_A0 = pick_val(); req_B0 = pick_val(); req_op0 = pick_op();
      req_A1 = pick_val(); req_B1 = pick_val(); req_op1 = pick_op();
      req_valid = 2'($urandom_range(0, 3));
      if (req_valid == 2'b00) begin
        #1;
        check("idle_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
      end else begin
        serve(int'($urandom_range(0, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
